register_file_dumper: RTL and testbench
=======================================

// Module: register_file_dumper
// PURPOSE
//  Reader side of the register file: on command, walks all RAM_DEPTH entries through an
//  asynchronous read port and streams each word as NB_BYTE-bit bytes over a valid/ready
//  byte link. The debug unit uses it to dump CPU registers to the UART transmitter.
//  Sits between the register file's spare read port and the UART TX byte interface.
// PARAMETERS
//  NB_ADDR     5              read address width
//  NB_DATA     32             register word width; must be an integer multiple of NB_BYTE
//  NB_BYTE     8              width of one transmitted byte
//  RAM_DEPTH   2**NB_ADDR     number of entries dumped (addr 0 .. RAM_DEPTH-1)
//  LSB_FIRST   0              0: most significant byte of each word sent first; 1: least
// PORTS
//  i_clock      in   1        single clock; all state updates on rising edge
//  i_reset      in   1        synchronous, active-high reset
//  i_start      in   1        one-cycle dump request; sampled only in IDLE
//  o_busy       out  1        high from the cycle after an accepted i_start until DONE inclusive
//  o_done       out  1        one-cycle pulse after the final byte is accepted
//  o_read_addr  out  NB_ADDR  register file read address (async read, data same cycle)
//  i_read_data  in   NB_DATA  register file read data for o_read_addr
//  o_tx_data    out  NB_BYTE  byte to transmit
//  o_tx_valid   out  1        o_tx_data valid
//  i_tx_ready   in   1        sink accepts byte when o_tx_valid & i_tx_ready at rising edge
// BEHAVIOUR
//  - Reset (any state, any cycle): state=IDLE; o_busy=0, o_done=0, o_tx_valid=0,
//    o_tx_data=0, o_read_addr=0, byte counter=0, word register=0. Transfer in flight is dropped.
//  - Derived: NB_BPW = NB_DATA/NB_BYTE bytes per word; byte counter width clog2(NB_BPW).
//  - FSM states: IDLE, LOAD, SEND, DONE.
//    IDLE: i_start=1 -> LOAD, o_read_addr=0. i_start ignored in all other states.
//    LOAD: one cycle; capture i_read_data into word register; byte counter=0 -> SEND.
//    SEND: o_tx_valid=1, o_tx_data=selected byte of word register. On handshake:
//          not last byte -> byte counter+1, stay SEND;
//          last byte and o_read_addr<RAM_DEPTH-1 -> o_read_addr+1, LOAD;
//          last byte and o_read_addr==RAM_DEPTH-1 -> DONE (no address wrap).
//    DONE: o_done=1, o_busy=1 for exactly one cycle -> IDLE; o_read_addr returns to 0.
//  - o_tx_data and o_tx_valid stable while o_tx_valid & !i_tx_ready (no drop, no change).
//  - o_tx_valid never deasserts in SEND without a handshake; low in IDLE/LOAD/DONE.
//  - Byte order: LSB_FIRST=0 -> byte k = word[NB_DATA-1-k*NB_BYTE -: NB_BYTE]; else word[k*NB_BYTE +: NB_BYTE].
//  - Latency (ready always high): i_start sampled at edge t -> LOAD in cycle t+1, first
//    valid byte in t+2; per word 1+NB_BPW cycles; o_done in cycle t+1+RAM_DEPTH*(1+NB_BPW).
//    Default: 128 bytes, o_done at t+161.
//  - Register file writes during a dump are allowed; each word is sampled once in its LOAD cycle.
//  - i_start coincident with i_reset: reset wins, no dump starts.
// STRUCTURE
//  - Shared package: FSM state encodings (IDLE/LOAD/SEND/DONE), NB_BYTE default,
//    NB_BPW derivation, byte-order selector constants; reused by debug unit and UART TX.
//  - One sub-module: word_serializer (load word, select byte by counter and LSB_FIRST,
//    report last byte). Dumper keeps FSM, address counter and handshake.
//  - Elaboration check: NB_DATA % NB_BYTE == 0, else fatal.
// TESTING
//  1 Reset then i_start, i_tx_ready=1, reg[n]=32'h0n0n_A5C3 -> 128 bytes in addr order,
//    first four 8'h00,8'h00,8'hA5,8'hC3; o_done single pulse at start+161.
//  2 LSB_FIRST=1, reg[1]=32'h11223344 -> bytes 5..8 are 44,33,22,11.
//  3 i_tx_ready random 30% -> byte sequence identical to test 1; o_tx_data never changes
//    while valid&!ready; no byte duplicated or lost.
//  4 i_reset asserted mid-dump (addr 7, byte 2) -> next cycle all outputs at reset values;
//    subsequent i_start restarts from addr 0 byte 0.
//  5 i_start pulsed repeatedly while busy -> ignored; exactly one dump of 128 bytes, one o_done.
//  6 Write reg[31]=32'hDEADBEEF while dumping addr 3 -> addr 31 dumps DEADBEEF; addr 3 keeps LOAD-cycle value.

Source files
------------

// File: rtl/register_file_dumper_pkg.sv
// Shared definitions for the register-dump path: FSM encodings, byte sizing
// helpers and byte-order selectors used by the dumper, debug unit and UART TX.
package register_file_dumper_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } dump_state_e;

    localparam int NB_BYTE_DEFAULT = 8;

    localparam bit BYTE_ORDER_MSB_FIRST = 1'b0;
    localparam bit BYTE_ORDER_LSB_FIRST = 1'b1;

    function automatic int calc_bpw(input int nb_data, input int nb_byte);
        return nb_data / nb_byte;
    endfunction

    // A one-byte word still needs a 1-bit counter to keep the port legal.
    function automatic int calc_cnt_width(input int bpw);
        return (bpw > 1) ? $clog2(bpw) : 1;
    endfunction

endpackage

// File: rtl/register_file_dumper_if.sv
// Bundles the dump command/status, register-file read port and the TX byte link.
interface register_file_dumper_if #(
    parameter int NB_ADDR = 5,
    parameter int NB_DATA = 32,
    parameter int NB_BYTE = 8
);
    logic               start;
    logic               busy;
    logic               done;
    logic [NB_ADDR-1:0] read_addr;
    logic [NB_DATA-1:0] read_data;
    logic [NB_BYTE-1:0] tx_data;
    logic               tx_valid;
    logic               tx_ready;

    modport master (
        input  start,
        input  read_data,
        input  tx_ready,
        output busy,
        output done,
        output read_addr,
        output tx_data,
        output tx_valid
    );

    modport slave (
        output start,
        output read_data,
        output tx_ready,
        input  busy,
        input  done,
        input  read_addr,
        input  tx_data,
        input  tx_valid
    );

endinterface

// File: rtl/register_file_dumper_word_serializer.sv
// Holds one register word and presents it byte by byte in the configured order.
module word_serializer
    import register_file_dumper_pkg::*;
#(
    parameter int NB_DATA   = 32,
    parameter int NB_BYTE   = NB_BYTE_DEFAULT,
    parameter bit LSB_FIRST = BYTE_ORDER_MSB_FIRST
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_load,
    input  logic               i_advance,
    input  logic [NB_DATA-1:0] i_word,
    output logic [NB_BYTE-1:0] o_byte,
    output logic               o_last
);

    localparam int NB_BPW = calc_bpw(NB_DATA, NB_BYTE);
    localparam int CNT_W  = calc_cnt_width(NB_BPW);

    logic [NB_DATA-1:0] word_q, word_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NB_BYTE-1:0] lanes [NB_BPW];

    // Lane k is the k-th byte on the wire, so the counter indexes lanes directly.
    for (genvar k = 0; k < NB_BPW; k++) begin : g_lane
        if (LSB_FIRST) begin : g_lsb
            assign lanes[k] = word_q[k*NB_BYTE +: NB_BYTE];
        end else begin : g_msb
            assign lanes[k] = word_q[NB_DATA-1-k*NB_BYTE -: NB_BYTE];
        end
    end

    assign o_byte = lanes[cnt_q];
    assign o_last = (cnt_q == CNT_W'(NB_BPW - 1));

    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        if (i_load) begin
            word_d = i_word;
            cnt_d  = '0;
        end else if (i_advance && !o_last) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/register_file_dumper.sv
// Walks every register-file entry on request and streams each word as bytes
// over a valid/ready link towards the UART transmitter.
module register_file_dumper
    import register_file_dumper_pkg::*;
#(
    parameter int NB_ADDR   = 5,
    parameter int NB_DATA   = 32,
    parameter int NB_BYTE   = NB_BYTE_DEFAULT,
    parameter int RAM_DEPTH = 2**NB_ADDR,
    parameter bit LSB_FIRST = BYTE_ORDER_MSB_FIRST
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    register_file_dumper_if.master bus
);

    localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(RAM_DEPTH - 1);

    if ((NB_DATA % NB_BYTE) != 0) begin : g_bad_width
        $fatal(1, "register_file_dumper: NB_DATA must be a multiple of NB_BYTE");
    end

    dump_state_e        state_q, state_d;
    logic [NB_ADDR-1:0] addr_q, addr_d;
    logic               load;
    logic               advance;
    logic [NB_BYTE-1:0] ser_byte;
    logic               ser_last;

    word_serializer #(
        .NB_DATA   (NB_DATA),
        .NB_BYTE   (NB_BYTE),
        .LSB_FIRST (LSB_FIRST)
    ) u_word_serializer (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .i_load    (load),
        .i_advance (advance),
        .i_word    (bus.read_data),
        .o_byte    (ser_byte),
        .o_last    (ser_last)
    );

    // The read port is asynchronous, so the word for addr_q is captured in LOAD.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        load    = 1'b0;
        advance = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_LOAD;
                    addr_d  = '0;
                end
            end
            ST_LOAD: begin
                load    = 1'b1;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (bus.tx_ready) begin
                    advance = 1'b1;
                    if (ser_last) begin
                        if (addr_q == LAST_ADDR) begin
                            state_d = ST_DONE;
                        end else begin
                            addr_d  = addr_q + NB_ADDR'(1);
                            state_d = ST_LOAD;
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                addr_d  = '0;
            end
            default: begin
                state_d = ST_IDLE;
                addr_d  = '0;
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.read_addr = addr_q;
    assign bus.tx_valid  = (state_q == ST_SEND);
    assign bus.tx_data   = (state_q == ST_SEND) ? ser_byte : '0;

endmodule

// File: tb/tb_register_file_dumper.sv
// Scoreboard bench for register_file_dumper: MSB-first and LSB-first instances
// share one register-file model and are driven by directed steps.
module tb_register_file_dumper;
    import register_file_dumper_pkg::*;

    localparam int NB_ADDR     = 5;
    localparam int NB_DATA     = 32;
    localparam int NB_BYTE     = 8;
    localparam int RAM_DEPTH   = 32;
    localparam int NB_BPW      = 4;
    localparam int TOTAL_BYTES = RAM_DEPTH * NB_BPW;
    localparam int DONE_CYCLE  = 1 + RAM_DEPTH * (1 + NB_BPW);

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    register_file_dumper_if #(.NB_ADDR(NB_ADDR), .NB_DATA(NB_DATA), .NB_BYTE(NB_BYTE)) bus_msb ();
    register_file_dumper_if #(.NB_ADDR(NB_ADDR), .NB_DATA(NB_DATA), .NB_BYTE(NB_BYTE)) bus_lsb ();

    logic [NB_DATA-1:0] regs [RAM_DEPTH];

    assign bus_msb.read_data = regs[bus_msb.read_addr];
    assign bus_lsb.read_data = regs[bus_lsb.read_addr];

    register_file_dumper #(
        .NB_ADDR(NB_ADDR), .NB_DATA(NB_DATA), .NB_BYTE(NB_BYTE),
        .RAM_DEPTH(RAM_DEPTH), .LSB_FIRST(BYTE_ORDER_MSB_FIRST)
    ) dut_msb (
        .i_clock (clock),
        .i_reset (reset),
        .bus     (bus_msb)
    );

    register_file_dumper #(
        .NB_ADDR(NB_ADDR), .NB_DATA(NB_DATA), .NB_BYTE(NB_BYTE),
        .RAM_DEPTH(RAM_DEPTH), .LSB_FIRST(BYTE_ORDER_LSB_FIRST)
    ) dut_lsb (
        .i_clock (clock),
        .i_reset (reset),
        .bus     (bus_lsb)
    );

    int compared   = 0;
    int mismatched = 0;
    logic [7:0] exp_q [$];

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic fill_regs();
        for (int n = 0; n < RAM_DEPTH; n++) begin
            regs[n] = {8'(n), 8'(n), 16'hA5C3};
        end
    endtask

    task automatic apply_stimulus(input logic start_val, input logic ready_val);
        @(negedge clock);
        bus_msb.start    = start_val;
        bus_msb.tx_ready = ready_val;
    endtask

    // Full dump on the MSB-first instance, scoreboarding every accepted byte.
    task automatic run_dump(input string name, input int ready_pct,
                            input bit spam_start, input bit write_mid);
        logic [NB_DATA-1:0] model [RAM_DEPTH];
        int   cyc;
        int   done_cyc;
        int   done_cnt;
        int   hs;
        bit   stall_prev;
        bit   wrote;
        bit   ready;
        logic [7:0] prev_data;
        cyc = 0; done_cyc = -1; done_cnt = 0; hs = 0;
        stall_prev = 1'b0; wrote = 1'b0; prev_data = '0;

        for (int a = 0; a < RAM_DEPTH; a++) model[a] = regs[a];
        if (write_mid) model[31] = 32'hDEADBEEF;
        exp_q.delete();
        for (int a = 0; a < RAM_DEPTH; a++)
            for (int k = 0; k < NB_BPW; k++)
                exp_q.push_back(model[a][NB_DATA-1-k*NB_BYTE -: NB_BYTE]);

        apply_stimulus(1'b1, 1'b1);
        @(posedge clock);
        while (cyc < 4000 && done_cnt == 0) begin
            @(negedge clock);
            cyc++;
            if (cyc == 1) begin
                check_output({name, " busy_after_start"}, 32'(bus_msb.busy), 32'd1);
                check_output({name, " valid_in_load"}, 32'(bus_msb.tx_valid), 32'd0);
            end
            if (stall_prev) begin
                check_output({name, " hold_valid"}, 32'(bus_msb.tx_valid), 32'd1);
                check_output({name, " hold_data"}, 32'(bus_msb.tx_data), 32'(prev_data));
            end
            if (bus_msb.done) begin
                done_cnt++;
                done_cyc = cyc;
                check_output({name, " busy_in_done"}, 32'(bus_msb.busy), 32'd1);
                bus_msb.start = 1'b0;
            end else begin
                bus_msb.start = spam_start ? logic'(cyc % 2) : 1'b0;
            end
            if (write_mid && !wrote && bus_msb.read_addr == 5'd3 && bus_msb.tx_valid) begin
                regs[31] = 32'hDEADBEEF;
                regs[3]  = 32'h33333333;
                wrote    = 1'b1;
            end
            ready = ($urandom_range(0, 99) < ready_pct);
            bus_msb.tx_ready = ready;
            if (bus_msb.tx_valid && ready) begin
                hs++;
                if (exp_q.size() > 0)
                    check_output($sformatf("%s byte%0d", name, hs - 1),
                                 32'(bus_msb.tx_data), 32'(exp_q.pop_front()));
                else
                    check_output($sformatf("%s extra_byte%0d", name, hs - 1), 32'(hs), 32'(TOTAL_BYTES));
            end
            stall_prev = bus_msb.tx_valid && !ready;
            prev_data  = bus_msb.tx_data;
        end
        check_output({name, " done_seen"}, 32'(done_cnt), 32'd1);
        check_output({name, " byte_count"}, 32'(hs), 32'(TOTAL_BYTES));
        check_output({name, " queue_empty"}, 32'(exp_q.size()), 32'd0);
        if (ready_pct >= 100)
            check_output({name, " done_cycle"}, 32'(done_cyc), 32'(DONE_CYCLE));
        @(negedge clock);
        check_output({name, " done_pulse"}, 32'(bus_msb.done), 32'd0);
        check_output({name, " idle_busy"}, 32'(bus_msb.busy), 32'd0);
        check_output({name, " idle_addr"}, 32'(bus_msb.read_addr), 32'd0);
        @(negedge clock);
        check_output({name, " stays_idle"}, 32'(bus_msb.busy), 32'd0);
    endtask

    initial begin
        logic [7:0] lsb_bytes [TOTAL_BYTES];
        logic [7:0] lsb_exp [4];
        int hs;
        int cyc;
        int done_cnt;

        reset = 1'b1;
        bus_msb.start = 1'b0; bus_msb.tx_ready = 1'b0;
        bus_lsb.start = 1'b0; bus_lsb.tx_ready = 1'b0;
        fill_regs();
        repeat (3) @(negedge clock);
        check_output("reset busy", 32'(bus_msb.busy), 32'd0);
        check_output("reset done", 32'(bus_msb.done), 32'd0);
        check_output("reset valid", 32'(bus_msb.tx_valid), 32'd0);
        check_output("reset data", 32'(bus_msb.tx_data), 32'd0);
        check_output("reset addr", 32'(bus_msb.read_addr), 32'd0);
        reset = 1'b0;

        $display("[TB] test 1: full dump, ready always high");
        run_dump("t1", 100, 1'b0, 1'b0);

        $display("[TB] test 2: LSB-first instance");
        regs[1] = 32'h11223344;
        for (int i = 0; i < TOTAL_BYTES; i++) lsb_bytes[i] = '0;
        lsb_exp[0] = 8'h44; lsb_exp[1] = 8'h33; lsb_exp[2] = 8'h22; lsb_exp[3] = 8'h11;
        @(negedge clock);
        bus_lsb.start = 1'b1; bus_lsb.tx_ready = 1'b1;
        hs = 0; cyc = 0; done_cnt = 0;
        while (cyc < 1000 && done_cnt == 0) begin
            @(negedge clock);
            cyc++;
            bus_lsb.start = 1'b0;
            if (bus_lsb.done) done_cnt++;
            if (bus_lsb.tx_valid) begin
                if (hs < TOTAL_BYTES) lsb_bytes[hs] = bus_lsb.tx_data;
                hs++;
            end
        end
        check_output("t2 done_seen", 32'(done_cnt), 32'd1);
        check_output("t2 byte_count", 32'(hs), 32'(TOTAL_BYTES));
        check_output("t2 byte0", 32'(lsb_bytes[0]), 32'h0000_00C3);
        for (int k = 0; k < 4; k++)
            check_output($sformatf("t2 byte%0d", 4 + k), 32'(lsb_bytes[4 + k]), 32'(lsb_exp[k]));
        fill_regs();
        repeat (2) @(negedge clock);

        $display("[TB] test 3: random backpressure");
        run_dump("t3", 70, 1'b0, 1'b0);

        $display("[TB] test 5: start spammed while busy");
        run_dump("t5", 100, 1'b1, 1'b0);

        $display("[TB] test 6: register write during dump");
        run_dump("t6", 100, 1'b0, 1'b1);
        fill_regs();

        $display("[TB] test 4: reset mid-dump");
        apply_stimulus(1'b1, 1'b1);
        hs = 0; cyc = 0;
        while (cyc < 1000) begin
            @(negedge clock);
            cyc++;
            bus_msb.start = 1'b0;
            if (bus_msb.tx_valid) begin
                if (hs == 7 * NB_BPW + 2) break;
                hs++;
            end
        end
        check_output("t4 abort_addr", 32'(bus_msb.read_addr), 32'd7);
        check_output("t4 abort_byte", 32'(bus_msb.tx_data), 32'h0000_00A5);
        reset = 1'b1;
        bus_msb.start = 1'b1;
        @(negedge clock);
        check_output("t4 busy", 32'(bus_msb.busy), 32'd0);
        check_output("t4 done", 32'(bus_msb.done), 32'd0);
        check_output("t4 valid", 32'(bus_msb.tx_valid), 32'd0);
        check_output("t4 data", 32'(bus_msb.tx_data), 32'd0);
        check_output("t4 addr", 32'(bus_msb.read_addr), 32'd0);
        reset = 1'b0;
        bus_msb.start = 1'b0;
        @(negedge clock);
        check_output("t4 no_start_on_reset", 32'(bus_msb.busy), 32'd0);
        run_dump("t4r", 100, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
